// File: rtl/control_defs_pkg.sv
// Shared definitions for the control sequencer: widths, opcodes, FSM states
// and instruction field positions.
package control_defs;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_PCRD = 4'h3;
  localparam logic [3:0] OP_HALT = 4'h7;
  localparam logic       ALU_PREFIX = 1'b1;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EX1  = 3'd1,
    S_EX2  = 3'd2,
    S_EX3  = 3'd3,
    S_EX4  = 3'd4,
    S_HALT = 3'd5
  } state_t;

endpackage

// File: rtl/reg_sel_decoder.sv
// 2-bit register index plus enable to one-hot select for r0-r3.
module reg_sel_decoder (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] onehot_c
);

  always_comb begin
    onehot_c = 4'b0000;
    if (en) onehot_c[idx] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded Moore sequencer driving datapath strobes; outputs are registered
// from the next state so they always reflect the current state and IR.
module control_sequencer
  import control_defs::*;
#(
  parameter int unsigned IW  = INSTR_W,
  parameter int unsigned OPW = ALU_OP_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [IW-1:0] imm_out,
  output logic          imm_en,
  output logic          ALUin0,
  output logic          ALUin1,
  output logic          ALUOutLatch,
  output logic          ALUOutEn,
  output logic [OPW-1:0] opControl,
  output logic          PCOutEn,
  output logic [3:0]    r_latch,
  output logic [3:0]    r_out,
  output logic          done,
  output logic          halted
);

  state_t        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;

  logic [3:0]    opc_d;
  logic [1:0]    rd_d, rs_d;
  logic [7:0]    imm8_d;
  logic          is_alu_d;

  logic          ready_d, imm_en_d, a0_d, a1_d, aol_d, aoe_d, pc_d, done_d, halted_d;
  logic [IW-1:0] imm_d;
  logic [OPW-1:0] op_d;
  logic          lat_en, out_en;
  logic [1:0]    lat_idx, out_idx;
  logic [3:0]    lat_d, out_d;

  // Next state and IR capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        state_d = S_EX1;
        ir_d    = instr;
      end
      S_EX1: begin
        if (ir_q[OPC_MSB] == ALU_PREFIX)                 state_d = S_EX2;
        else if (ir_q[OPC_MSB:OPC_LSB] == OP_HALT)       state_d = S_HALT;
        else                                             state_d = S_IDLE;
      end
      S_EX2:   state_d = S_EX3;
      S_EX3:   state_d = S_EX4;
      S_EX4:   state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign opc_d    = ir_d[OPC_MSB:OPC_LSB];
  assign rd_d     = ir_d[RD_MSB:RD_LSB];
  assign rs_d     = ir_d[RS_MSB:RS_LSB];
  assign imm8_d   = ir_d[IMM_MSB:IMM_LSB];
  assign is_alu_d = (opc_d[3] == ALU_PREFIX);

  // Output decode for the state being entered
  always_comb begin
    ready_d  = 1'b0;
    imm_en_d = 1'b0;
    imm_d    = '0;
    a0_d     = 1'b0;
    a1_d     = 1'b0;
    aol_d    = 1'b0;
    aoe_d    = 1'b0;
    op_d     = '0;
    pc_d     = 1'b0;
    done_d   = 1'b0;
    halted_d = 1'b0;
    lat_en   = 1'b0;
    lat_idx  = rd_d;
    out_en   = 1'b0;
    out_idx  = rd_d;
    case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_EX1: begin
        if (is_alu_d) begin
          out_en = 1'b1;
          a0_d   = 1'b1;
          op_d   = OPW'(opc_d[2:0]);
        end else begin
          done_d = 1'b1;
          case (opc_d)
            OP_LDI: begin
              imm_en_d = 1'b1;
              imm_d    = IW'(imm8_d);
              lat_en   = 1'b1;
            end
            OP_MOV: begin
              out_en  = 1'b1;
              out_idx = rs_d;
              lat_en  = 1'b1;
            end
            OP_PCRD: begin
              pc_d   = 1'b1;
              lat_en = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_EX2: begin
        out_en  = 1'b1;
        out_idx = rs_d;
        a1_d    = 1'b1;
        op_d    = OPW'(opc_d[2:0]);
      end
      S_EX3: begin
        aol_d = 1'b1;
        op_d  = OPW'(opc_d[2:0]);
      end
      S_EX4: begin
        aoe_d  = 1'b1;
        lat_en = 1'b1;
        done_d = 1'b1;
        op_d   = OPW'(opc_d[2:0]);
      end
      S_HALT:  halted_d = 1'b1;
      default: ;
    endcase
  end

  reg_sel_decoder u_lat_dec (.idx(lat_idx), .en(lat_en), .onehot_c(lat_d));
  reg_sel_decoder u_out_dec (.idx(out_idx), .en(out_en), .onehot_c(out_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      instr_ready <= 1'b1;
      imm_en      <= 1'b0;
      imm_out     <= '0;
      ALUin0      <= 1'b0;
      ALUin1      <= 1'b0;
      ALUOutLatch <= 1'b0;
      ALUOutEn    <= 1'b0;
      opControl   <= '0;
      PCOutEn     <= 1'b0;
      r_latch     <= 4'b0000;
      r_out       <= 4'b0000;
      done        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      instr_ready <= ready_d;
      imm_en      <= imm_en_d;
      imm_out     <= imm_d;
      ALUin0      <= a0_d;
      ALUin1      <= a1_d;
      ALUOutLatch <= aol_d;
      ALUOutEn    <= aoe_d;
      opControl   <= op_d;
      PCOutEn     <= pc_d;
      r_latch     <= lat_d;
      r_out       <= out_d;
      done        <= done_d;
      halted      <= halted_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus multi-cycle sequences.
module tb_control_sequencer;

  logic        clk, rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready, imm_en, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, PCOutEn, done, halted;
  logic [15:0] imm_out;
  logic [2:0]  opControl;
  logic [3:0]  r_latch, r_out;

  control_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .imm_out(imm_out), .imm_en(imm_en),
    .ALUin0(ALUin0), .ALUin1(ALUin1), .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn),
    .opControl(opControl), .PCOutEn(PCOutEn), .r_latch(r_latch), .r_out(r_out),
    .done(done), .halted(halted)
  );

  typedef struct packed {
    logic        ie;
    logic [15:0] io;
    logic        a0, a1, aol, aoe;
    logic [2:0]  op;
    logic        pc;
    logic [3:0]  rl, ro;
    logic        dn, rdy, hl;
  } snap_t;

  typedef struct {
    logic [15:0] ins;
    bit          first;
    snap_t       exp;
    string       name;
  } row_t;

  row_t tbl[$];
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input logic ie, input logic [15:0] io,
                               input logic a0, input logic a1, input logic aol, input logic aoe,
                               input logic [2:0] op, input logic pc,
                               input logic [3:0] rl, input logic [3:0] ro,
                               input logic dn, input logic rdy, input logic hl);
    snap_t s;
    s.ie = ie; s.io = io; s.a0 = a0; s.a1 = a1; s.aol = aol; s.aoe = aoe;
    s.op = op; s.pc = pc; s.rl = rl; s.ro = ro; s.dn = dn; s.rdy = rdy; s.hl = hl;
    return s;
  endfunction

  function automatic snap_t actual();
    return mk(imm_en, imm_out, ALUin0, ALUin1, ALUOutLatch, ALUOutEn, opControl,
              PCOutEn, r_latch, r_out, done, instr_ready, halted);
  endfunction

  task automatic check(input string name, input snap_t exp);
    snap_t act;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (ie,io,a0,a1,aol,aoe,op,pc,rl,ro,dn,rdy,hl)",
               name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [15:0] ins, input bit first, input snap_t e);
    row_t r;
    r.ins = ins; r.first = first; r.exp = e; r.name = name;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // At most one bus driver per cycle
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones({imm_en, ALUOutEn, PCOutEn, r_out}) > 1) begin
        errors++;
        $display("FAIL bus_onehot: got drivers=%b required at most one",
                 {imm_en, ALUOutEn, PCOutEn, r_out});
      end
    end
  end

  snap_t idle_s, done_s, halt_s;

  initial begin
    idle_s = mk(0, 16'h0, 0, 0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    done_s = mk(0, 16'h0, 0, 0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    halt_s = mk(0, 16'h0, 0, 0, 0, 0, 3'd0, 0, 4'b0000, 4'b0000, 0, 0, 1);

    add("nop_ex1",   16'h0000, 1, done_s);
    add("nop_idle",  16'h0000, 0, idle_s);
    add("ldi_ex1",   16'h185A, 1, mk(1, 16'h005A, 0, 0, 0, 0, 3'd0, 0, 4'b0100, 4'b0000, 1, 0, 0));
    add("ldi_idle",  16'h0000, 0, idle_s);
    add("mov_ex1",   16'h2B00, 1, mk(0, 16'h0, 0, 0, 0, 0, 3'd0, 0, 4'b0100, 4'b1000, 1, 0, 0));
    add("mov_idle",  16'h0000, 0, idle_s);
    add("pcrd_ex1",  16'h3C00, 1, mk(0, 16'h0, 0, 0, 0, 0, 3'd0, 1, 4'b1000, 4'b0000, 1, 0, 0));
    add("pcrd_idle", 16'h0000, 0, idle_s);
    add("add_ex1",   16'h8400, 1, mk(0, 16'h0, 1, 0, 0, 0, 3'd0, 0, 4'b0000, 4'b0010, 0, 0, 0));
    add("add_ex2",   16'h0000, 0, mk(0, 16'h0, 0, 1, 0, 0, 3'd0, 0, 4'b0000, 4'b0001, 0, 0, 0));
    add("add_ex3",   16'h0000, 0, mk(0, 16'h0, 0, 0, 1, 0, 3'd0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    add("add_ex4",   16'h0000, 0, mk(0, 16'h0, 0, 0, 0, 1, 3'd0, 0, 4'b0010, 4'b0000, 1, 0, 0));
    add("add_idle",  16'h0000, 0, idle_s);
    add("self_ex1",  16'hA500, 1, mk(0, 16'h0, 1, 0, 0, 0, 3'd2, 0, 4'b0000, 4'b0010, 0, 0, 0));
    add("self_ex2",  16'h0000, 0, mk(0, 16'h0, 0, 1, 0, 0, 3'd2, 0, 4'b0000, 4'b0010, 0, 0, 0));
    add("self_ex3",  16'h0000, 0, mk(0, 16'h0, 0, 0, 1, 0, 3'd2, 0, 4'b0000, 4'b0000, 0, 0, 0));
    add("self_ex4",  16'h0000, 0, mk(0, 16'h0, 0, 0, 0, 1, 3'd2, 0, 4'b0010, 4'b0000, 1, 0, 0));
    add("self_idle", 16'h0000, 0, idle_s);
    add("rsv_ex1",   16'h5FFF, 1, done_s);
    add("rsv_idle",  16'h0000, 0, idle_s);
    add("op7_ex1",   16'hF6FF, 1, mk(0, 16'h0, 1, 0, 0, 0, 3'd7, 0, 4'b0000, 4'b0010, 0, 0, 0));
    add("op7_ex2",   16'h0000, 0, mk(0, 16'h0, 0, 1, 0, 0, 3'd7, 0, 4'b0000, 4'b0100, 0, 0, 0));
    add("op7_ex3",   16'h0000, 0, mk(0, 16'h0, 0, 0, 1, 0, 3'd7, 0, 4'b0000, 4'b0000, 0, 0, 0));
    add("op7_ex4",   16'h0000, 0, mk(0, 16'h0, 0, 0, 0, 1, 3'd7, 0, 4'b0010, 4'b0000, 1, 0, 0));
    add("op7_idle",  16'h0000, 0, idle_s);
    add("movself",   16'h2000, 1, mk(0, 16'h0, 0, 0, 0, 0, 3'd0, 0, 4'b0001, 4'b0001, 1, 0, 0));
    add("movself_i", 16'h0000, 0, idle_s);

    rst = 1'b1; instr = 16'h0; instr_valid = 1'b0;
    repeat (2) step();
    check("reset_hold", idle_s);
    rst = 1'b0;
    step();
    check("post_reset", idle_s);

    foreach (tbl[i]) begin
      if (tbl[i].first) begin
        instr = tbl[i].ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
      end else begin
        step();
      end
      check(tbl[i].name, tbl[i].exp);
    end

    // valid held high with a changing word during an ALU op
    instr = 16'h8400; instr_valid = 1'b1;
    step(); check("hs_ex1", mk(0, 16'h0, 1, 0, 0, 0, 3'd0, 0, 4'b0000, 4'b0010, 0, 0, 0));
    instr = 16'h2100;
    step(); check("hs_ex2", mk(0, 16'h0, 0, 1, 0, 0, 3'd0, 0, 4'b0000, 4'b0001, 0, 0, 0));
    instr = 16'h3200;
    step(); check("hs_ex3", mk(0, 16'h0, 0, 0, 1, 0, 3'd0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    instr = 16'h1C33;
    step(); check("hs_ex4", mk(0, 16'h0, 0, 0, 0, 1, 3'd0, 0, 4'b0010, 4'b0000, 1, 0, 0));
    step(); check("hs_idle", idle_s);
    step(); check("hs_next", mk(1, 16'h0033, 0, 0, 0, 0, 3'd0, 0, 4'b1000, 4'b0000, 1, 0, 0));
    instr_valid = 1'b0;
    step(); check("hs_after", idle_s);

    // reset asserted mid-EX2 clears strobes immediately
    instr = 16'h8400; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step(); check("rst_ex2", mk(0, 16'h0, 0, 1, 0, 0, 3'd0, 0, 4'b0000, 4'b0001, 0, 0, 0));
    #1 rst = 1'b1;
    #1 check("rst_async", idle_s);
    step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); check("rst_no_wb", idle_s);
    end

    // HALT parks the unit until reset
    instr = 16'h7000; instr_valid = 1'b1;
    step(); check("halt_ex1", done_s);
    instr = 16'h8400;
    for (int k = 0; k < 20; k++) begin
      step(); check("halt_park", halt_s);
    end
    rst = 1'b1;
    #1 check("halt_rst", idle_s);
    instr_valid = 1'b0;
    step(); rst = 1'b0;
    step(); check("halt_exit", idle_s);
    instr = 16'h0000; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    check("halt_then_nop", done_s);
    step(); check("halt_then_idle", idle_s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
